// File: rtl/addsub_chunked_pkg.sv
// Shared encodings for the chunked add/subtract unit: operation select,
// FSM states and the operand-preparation helpers.
package addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ADDC = 2'b10,
      OP_SUBC = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   function automatic logic op_is_sub(input op_e op);
      return (op == OP_SUB) || (op == OP_SUBC);
   endfunction

   // Subtraction is a + ~b + 1; the chained variants take the carry from CIN.
   function automatic logic op_carry0(input op_e op, input logic cin);
      logic c;
      case (op)
         OP_ADD:  c = 1'b0;
         OP_SUB:  c = 1'b1;
         default: c = cin;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/addsub_chunked_addc.sv
// Combinational CHUNK-bit adder with carry-in; one slice of the multi-cycle
// carry chain.
module addc_chunk #(
   parameter int CHUNK = 8
) (
   input  logic             cin_i,
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/addsub_chunked.sv
// Multi-cycle WIDTH-bit add/subtract: CHUNK bits per clock, carry held in a
// register between cycles, results and flags presented behind valid/ready.
module addsub_chunked
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             I_VALID,
   output logic             I_READY,
   input  logic [1:0]       OP,
   input  logic             CIN,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   output logic             O_VALID,
   input  logic             O_READY,
   output logic [WIDTH-1:0] O,
   output logic             COUT,
   output logic             V,
   output logic             Z,
   output state_e           dbg_state_o
);

   // Handshake: a request transfers on a rising edge with I_VALID && I_READY;
   // a result transfers on a rising edge with O_VALID && O_READY. Neither side
   // may depend combinationally on the other.

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   state_e                        state_q;
   logic [NCHUNK-1:0][CHUNK-1:0]  a_q, b_q, work_q, work_d;
   logic [IDXW-1:0]               idx_q;
   logic                          carry_q;
   logic                          ready_q, valid_q;
   logic [WIDTH-1:0]              o_q;
   logic                          cout_q, v_q, z_q;

   logic [CHUNK-1:0]              sum_chunk;
   logic                          c_out;

   addc_chunk #(.CHUNK(CHUNK)) u_addc (
      .cin_i  (carry_q),
      .a_i    (a_q[idx_q]),
      .b_i    (b_q[idx_q]),
      .sum_o  (sum_chunk),
      .cout_o (c_out)
   );

   // Partial result accumulates here so O keeps the previous result until completion.
   always_comb begin
      work_d        = work_q;
      work_d[idx_q] = sum_chunk;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         o_q     <= '0;
         cout_q  <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (I_VALID) begin
                  a_q     <= I0;
                  b_q     <= op_is_sub(op_e'(OP)) ? ~I1 : I1;
                  carry_q <= op_carry0(op_e'(OP), CIN);
                  idx_q   <= '0;
                  ready_q <= 1'b0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               work_q  <= work_d;
               carry_q <= c_out;
               idx_q   <= idx_q + IDXW'(1);
               if (idx_q == LAST_IDX) begin
                  o_q     <= work_d;
                  cout_q  <= c_out;
                  v_q     <= (a_q[NCHUNK-1][CHUNK-1] == b_q[NCHUNK-1][CHUNK-1]) &&
                             (sum_chunk[CHUNK-1] != a_q[NCHUNK-1][CHUNK-1]);
                  z_q     <= (work_d == '0);
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (O_READY) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign I_READY     = ready_q;
   assign O_VALID     = valid_q;
   assign O           = o_q;
   assign COUT        = cout_q;
   assign V           = v_q;
   assign Z           = z_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_addsub_chunked.sv
// Directed bench for addsub_chunked (WIDTH=32, CHUNK=8): hand-computed
// results, flags, latency, backpressure and reset abort.
module tb_addsub_chunked;
   import addsub_pkg::*;

   localparam int WIDTH  = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             reset;
   logic             i_valid;
   logic             i_ready;
   logic [1:0]       op;
   logic             cin;
   logic [WIDTH-1:0] i0, i1;
   logic             o_valid;
   logic             o_ready;
   logic [WIDTH-1:0] o;
   logic             cout, v, z;
   state_e           dbg_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   addsub_chunked #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .CLK         (clk),
      .RESET       (reset),
      .I_VALID     (i_valid),
      .I_READY     (i_ready),
      .OP          (op),
      .CIN         (cin),
      .I0          (i0),
      .I1          (i1),
      .O_VALID     (o_valid),
      .O_READY     (o_ready),
      .O           (o),
      .COUT        (cout),
      .V           (v),
      .Z           (z),
      .dbg_state_o (dbg_state)
   );

   // Drives one request, scrambles the inputs after the accepting edge, and
   // returns the number of edges until O_VALID (-1 on timeout). Leaves time
   // at #1 after the edge where O_VALID rose.
   task automatic run_op(input logic [1:0] op_v, input logic cin_v,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int lat, output logic ready_seen);
      int n;
      n = 0;
      @(negedge clk);
      while (!i_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      op = op_v; cin = cin_v; i0 = a; i1 = b; i_valid = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      cin = ~cin_v;
      i0 = $urandom_range(32'hFFFF_FFFF, 0);
      i1 = $urandom_range(32'hFFFF_FFFF, 0);
      ready_seen = i_ready;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (o_valid) begin
            lat = k;
            break;
         end
         ready_seen = ready_seen | i_ready;
      end
   endtask

   task automatic drain();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
      op = 2'b00; cin = 1'b0; i0 = '0; i1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL reset_i_ready got=%b exp=1", i_ready); end
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
      total++; if (o !== 32'h0) begin bad++; $display("FAIL reset_o got=%h exp=0", o); end
      total++; if ({cout, v, z} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {cout, v, z}); end
      total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
      reset = 1'b0;
   endtask

   task automatic test_add_propagate();
      int lat; logic rs;
      run_op(2'b00, 1'b0, 32'h0000_00FF, 32'h0000_0001, lat, rs);
      total++; if (lat != NCHUNK) begin bad++; $display("FAIL prop_latency got=%0d exp=%0d", lat, NCHUNK); end
      total++; if (o !== 32'h0000_0100) begin bad++; $display("FAIL prop_o got=%h exp=00000100", o); end
      total++; if ({cout, v, z} !== 3'b000) begin bad++; $display("FAIL prop_flags got=%b exp=000", {cout, v, z}); end
      total++; if (rs !== 1'b0) begin bad++; $display("FAIL prop_ready_busy got=%b exp=0", rs); end
      total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL prop_ready_done got=%b exp=0", i_ready); end
      drain();
      total++; if ({o_valid, i_ready} !== 2'b01) begin bad++; $display("FAIL prop_after_hs got=%b exp=01", {o_valid, i_ready}); end
   endtask

   task automatic test_sub();
      int lat; logic rs;
      logic [WIDTH-1:0] first;
      run_op(2'b01, 1'b0, 32'd5, 32'd7, lat, rs);
      total++; if (o !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_o got=%h exp=fffffffe", o); end
      total++; if ({cout, v, z} !== 3'b000) begin bad++; $display("FAIL sub_flags got=%b exp=000", {cout, v, z}); end
      drain();
      run_op(2'b00, 1'b0, 32'h10, 32'h25, lat, rs);
      first = o;
      total++; if (first !== 32'h35) begin bad++; $display("FAIL chain_add_o got=%h exp=00000035", first); end
      drain();
      run_op(2'b01, 1'b0, first, 32'h10, lat, rs);
      total++; if (o !== 32'h25) begin bad++; $display("FAIL chain_sub_o got=%h exp=00000025", o); end
      total++; if ({cout, v, z} !== 3'b100) begin bad++; $display("FAIL chain_sub_flags got=%b exp=100", {cout, v, z}); end
      drain();
   endtask

   task automatic test_overflow_zero();
      int lat; logic rs;
      run_op(2'b00, 1'b0, 32'h7FFF_FFFF, 32'h1, lat, rs);
      total++; if (o !== 32'h8000_0000) begin bad++; $display("FAIL ovf_o got=%h exp=80000000", o); end
      total++; if ({cout, v, z} !== 3'b010) begin bad++; $display("FAIL ovf_flags got=%b exp=010", {cout, v, z}); end
      drain();
      run_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'h1, lat, rs);
      total++; if (o !== 32'h0) begin bad++; $display("FAIL zero_o got=%h exp=00000000", o); end
      total++; if ({cout, v, z} !== 3'b101) begin bad++; $display("FAIL zero_flags got=%b exp=101", {cout, v, z}); end
      drain();
   endtask

   task automatic test_carry_in();
      int lat; logic rs;
      run_op(2'b10, 1'b1, 32'h1234_5678, 32'h1111_1111, lat, rs);
      total++; if (o !== 32'h2345_678A) begin bad++; $display("FAIL addc_o got=%h exp=2345678a", o); end
      total++; if (cout !== 1'b0) begin bad++; $display("FAIL addc_cout got=%b exp=0", cout); end
      drain();
      run_op(2'b11, 1'b0, 32'd10, 32'd3, lat, rs);
      total++; if (o !== 32'd6) begin bad++; $display("FAIL subc_borrow_o got=%h exp=00000006", o); end
      total++; if (cout !== 1'b1) begin bad++; $display("FAIL subc_borrow_cout got=%b exp=1", cout); end
      drain();
      run_op(2'b11, 1'b1, 32'd10, 32'd3, lat, rs);
      total++; if (o !== 32'd7) begin bad++; $display("FAIL subc_noborrow_o got=%h exp=00000007", o); end
      drain();
      run_op(2'b00, 1'b1, 32'd10, 32'd3, lat, rs);
      total++; if (o !== 32'd13) begin bad++; $display("FAIL add_ignores_cin got=%h exp=0000000d", o); end
      drain();
   endtask

   task automatic test_backpressure();
      int lat; logic rs;
      int unstable;
      o_ready = 1'b0;
      run_op(2'b00, 1'b0, 32'h100, 32'h23, lat, rs);
      total++; if (o !== 32'h123) begin bad++; $display("FAIL bp_o got=%h exp=00000123", o); end
      unstable = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         i_valid = 1'b1; op = 2'b01;
         i0 = $urandom_range(32'hFFFF_FFFF, 0); i1 = $urandom_range(32'hFFFF_FFFF, 0);
         @(posedge clk);
         #1;
         if (!o_valid || i_ready || o !== 32'h123 || {cout, v, z} !== 3'b000) unstable++;
      end
      total++; if (unstable != 0) begin bad++; $display("FAIL bp_hold got=%0d_bad_cycles exp=0", unstable); end
      @(negedge clk);
      i_valid = 1'b0; o_ready = 1'b1;
      @(posedge clk);
      #1;
      total++; if ({o_valid, i_ready} !== 2'b01) begin bad++; $display("FAIL bp_release got=%b exp=01", {o_valid, i_ready}); end
      total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL bp_state got=%0d exp=%0d", dbg_state, IDLE); end
      total++; if (o !== 32'h123) begin bad++; $display("FAIL bp_persist got=%h exp=00000123", o); end
   endtask

   task automatic test_reset_mid_busy();
      int lat; logic rs;
      int spurious;
      @(negedge clk);
      op = 2'b00; cin = 1'b0; i0 = 32'h0101_0101; i1 = 32'h0202_0202; i_valid = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_busy_state got=%0d exp=%0d", dbg_state, IDLE); end
      total++; if ({o_valid, i_ready} !== 2'b01) begin bad++; $display("FAIL rst_busy_hs got=%b exp=01", {o_valid, i_ready}); end
      total++; if (o !== 32'h0) begin bad++; $display("FAIL rst_busy_o got=%h exp=00000000", o); end
      @(negedge clk);
      reset = 1'b0;
      spurious = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (o_valid) spurious++;
      end
      total++; if (spurious != 0) begin bad++; $display("FAIL rst_busy_no_result got=%0d exp=0", spurious); end
      run_op(2'b00, 1'b0, 32'd1, 32'd2, lat, rs);
      total++; if (lat != NCHUNK) begin bad++; $display("FAIL after_rst_latency got=%0d exp=%0d", lat, NCHUNK); end
      total++; if (o !== 32'd3) begin bad++; $display("FAIL after_rst_o got=%h exp=00000003", o); end
      drain();
   endtask

   initial begin
      test_reset();
      test_add_propagate();
      test_sub();
      test_overflow_zero();
      test_carry_in();
      test_backpressure();
      test_reset_mid_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
